// File: rtl/traffic_light_pkg.sv
// Lamp codes, phase and error enumerations shared by the traffic-light controller and its monitor.
package traffic_light_pkg;

    localparam logic [2:0] CODE_RED    = 3'b100;
    localparam logic [2:0] CODE_YELLOW = 3'b010;
    localparam logic [2:0] CODE_GREEN  = 3'b001;
    localparam logic [2:0] CODE_OFF    = 3'b000;

    // PH_IDLE doubles as the monitor's UNLOCKED state.
    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_GREEN     = 3'd1,
        PH_BLINK_OFF = 3'd2,
        PH_BLINK_ON  = 3'd3,
        PH_YELLOW    = 3'd4,
        PH_RED       = 3'd5
    } phase_e;

    typedef enum logic [1:0] {
        ERR_ILLEGAL_CODE = 2'd0,
        ERR_TOO_SHORT    = 2'd1,
        ERR_TOO_LONG     = 2'd2,
        ERR_BAD_ORDER    = 2'd3
    } err_code_e;

    function automatic logic code_is_legal(input logic [2:0] code);
        return code inside {CODE_RED, CODE_YELLOW, CODE_GREEN, CODE_OFF};
    endfunction

    function automatic int len_max(input int a, input int b, input int c);
        int m;
        m = 2;
        if (a > m) m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_seg_counter.sv
// Segment length counter: clear, load-to-one, saturating increment, and an at-expected flag.
module tl_seg_counter #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] exp_len,
    output logic [CNT_W-1:0] cnt,
    output logic             at_exp
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(1);
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign at_exp = (cnt == exp_len);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker on the controller's lamp bus: tracks phase order and lengths, flags errors, counts cycles.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int GREEN_ON  = 40,
    parameter int YELLOW_ON = 5,
    parameter int RED_ON    = 15,
    parameter int BLINKING  = 3,
    parameter int CNT_W     = $clog2(len_max(GREEN_ON, YELLOW_ON, RED_ON)) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en_i,
    input  logic [2:0]       color_i,
    output logic [2:0]       phase_o,
    output logic [CNT_W-1:0] phase_cnt_o,
    output logic             locked_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic             cycle_done_o
);

    localparam int BLINK_W = (BLINKING > 1) ? $clog2(BLINKING) : 1;

    phase_e             state;
    err_code_e          err_code;
    logic [2:0]         prev_color;
    logic [BLINK_W-1:0] blink_idx;
    logic               in_cycle;

    logic [2:0]       cur_code;
    logic [2:0]       adv_code;
    phase_e           adv_state;
    logic [CNT_W-1:0] exp_len;
    logic             cnt_eq;
    logic             unlocked;
    logic             sync_hit;
    logic             same;
    logic             err_hit;
    err_code_e        err_kind;
    logic             advance;
    logic             cnt_clr;
    logic             cnt_load;
    logic             cnt_inc;

    // Per-segment lamp code, expected length and the segment that must follow it.
    always_comb begin
        cur_code  = CODE_OFF;
        exp_len   = '0;
        adv_state = PH_IDLE;
        adv_code  = CODE_OFF;
        unique case (state)
            PH_GREEN: begin
                cur_code  = CODE_GREEN;
                exp_len   = CNT_W'(GREEN_ON);
                adv_state = (BLINKING > 0) ? PH_BLINK_OFF : PH_YELLOW;
                adv_code  = (BLINKING > 0) ? CODE_OFF : CODE_YELLOW;
            end
            PH_BLINK_OFF: begin
                cur_code  = CODE_OFF;
                exp_len   = CNT_W'(1);
                adv_state = PH_BLINK_ON;
                adv_code  = CODE_GREEN;
            end
            PH_BLINK_ON: begin
                cur_code  = CODE_GREEN;
                exp_len   = CNT_W'(1);
                adv_state = (int'(blink_idx) < BLINKING - 1) ? PH_BLINK_OFF : PH_YELLOW;
                adv_code  = (int'(blink_idx) < BLINKING - 1) ? CODE_OFF : CODE_YELLOW;
            end
            PH_YELLOW: begin
                cur_code  = CODE_YELLOW;
                exp_len   = CNT_W'(YELLOW_ON);
                adv_state = PH_RED;
                adv_code  = CODE_RED;
            end
            PH_RED: begin
                cur_code  = CODE_RED;
                exp_len   = CNT_W'(RED_ON);
                adv_state = PH_GREEN;
                adv_code  = CODE_GREEN;
            end
            default: ;
        endcase
    end

    // Classify the current sample; checks are ordered illegal > short > order.
    always_comb begin
        unlocked = (state == PH_IDLE);
        sync_hit = (color_i == CODE_GREEN) && (prev_color == CODE_RED);
        same     = (color_i == cur_code);
        err_hit  = 1'b0;
        err_kind = ERR_ILLEGAL_CODE;
        advance  = 1'b0;
        if (en_i && !unlocked) begin
            if (same) begin
                if (cnt_eq) begin
                    err_hit  = 1'b1;
                    err_kind = ERR_TOO_LONG;
                end
            end else if (!code_is_legal(color_i)) begin
                err_hit  = 1'b1;
                err_kind = ERR_ILLEGAL_CODE;
            end else if (!cnt_eq) begin
                err_hit  = 1'b1;
                err_kind = ERR_TOO_SHORT;
            end else if (color_i != adv_code) begin
                err_hit  = 1'b1;
                err_kind = ERR_BAD_ORDER;
            end else begin
                advance = 1'b1;
            end
        end
        cnt_clr  = !en_i || err_hit || (unlocked && !sync_hit);
        cnt_load = unlocked ? sync_hit : advance;
        cnt_inc  = !unlocked && same;
    end

    tl_seg_counter #(
        .CNT_W (CNT_W)
    ) u_seg_counter (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (cnt_clr),
        .load    (cnt_load),
        .inc     (cnt_inc),
        .exp_len (exp_len),
        .cnt     (phase_cnt_o),
        .at_exp  (cnt_eq)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= PH_IDLE;
            err_code     <= ERR_ILLEGAL_CODE;
            prev_color   <= CODE_OFF;
            blink_idx    <= '0;
            in_cycle     <= 1'b0;
            locked_o     <= 1'b0;
            err_o        <= 1'b0;
            cycle_done_o <= 1'b0;
        end else begin
            err_o        <= 1'b0;
            cycle_done_o <= 1'b0;
            prev_color   <= color_i;
            if (!en_i) begin
                state    <= PH_IDLE;
                locked_o <= 1'b0;
                in_cycle <= 1'b0;
            end else if (unlocked) begin
                if (sync_hit) begin
                    state     <= PH_GREEN;
                    locked_o  <= 1'b1;
                    in_cycle  <= 1'b1;
                    blink_idx <= '0;
                end
            end else if (err_hit) begin
                state    <= PH_IDLE;
                locked_o <= 1'b0;
                in_cycle <= 1'b0;
                err_o    <= 1'b1;
                err_code <= err_kind;
            end else if (advance) begin
                state <= adv_state;
                if (state == PH_BLINK_ON && adv_state == PH_BLINK_OFF) begin
                    blink_idx <= blink_idx + BLINK_W'(1);
                end
                // RED -> GREEN closes one light cycle and opens the next.
                if (state == PH_RED) begin
                    cycle_done_o <= in_cycle;
                    in_cycle     <= 1'b1;
                    blink_idx    <= '0;
                end
            end
        end
    end

    assign phase_o    = state;
    assign err_code_o = err_code;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with GREEN_ON=4, YELLOW_ON=2, RED_ON=3, BLINKING=2.
module tb_traffic_light_monitor;
    import traffic_light_pkg::*;

    localparam int CNT_W = 3;
    localparam int EXP_W = 3 + CNT_W + 1 + 1 + 2 + 1;

    logic             clk;
    logic             rstn;
    logic             en_i;
    logic [2:0]       color_i;
    logic [2:0]       phase_o;
    logic [CNT_W-1:0] phase_cnt_o;
    logic             locked_o;
    logic             err_o;
    logic [1:0]       err_code_o;
    logic             cycle_done_o;

    logic [EXP_W-1:0] exp_q[$];
    logic [1:0]       e_code;
    int               n_checks;
    int               n_pass;

    traffic_light_monitor #(
        .GREEN_ON  (4),
        .YELLOW_ON (2),
        .RED_ON    (3),
        .BLINKING  (2)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .en_i         (en_i),
        .color_i      (color_i),
        .phase_o      (phase_o),
        .phase_cnt_o  (phase_cnt_o),
        .locked_o     (locked_o),
        .err_o        (err_o),
        .err_code_o   (err_code_o),
        .cycle_done_o (cycle_done_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".phase"}, int'(phase_o), 0);
        chk({tag, ".cnt"}, int'(phase_cnt_o), 0);
        chk({tag, ".locked"}, int'(locked_o), 0);
        chk({tag, ".err"}, int'(err_o), 0);
        chk({tag, ".err_code"}, int'(err_code_o), 0);
        chk({tag, ".done"}, int'(cycle_done_o), 0);
    endtask

    // Driver tasks: one sample per cycle, expected response queued for the next edge.
    task automatic step(input logic [2:0] c, input logic en, input logic [2:0] ph,
                        input int cnt, input logic lk, input logic er, input logic dn);
        logic [CNT_W-1:0] cv;
        @(negedge clk);
        color_i = c;
        en_i    = en;
        cv      = CNT_W'(cnt);
        exp_q.push_back({ph, cv, lk, er, e_code, dn});
    endtask

    task automatic unl(input logic [2:0] c);
        step(c, 1'b1, PH_IDLE, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lock_green();
        step(CODE_GREEN, 1'b1, PH_GREEN, 1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic seg(input logic [2:0] c, input logic [2:0] ph, input int from, input int to);
        for (int k = from; k <= to; k++) step(c, 1'b1, ph, k, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic err_step(input logic [2:0] c, input logic [1:0] code);
        e_code = code;
        step(c, 1'b1, PH_IDLE, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic green_and_blink();
        seg(CODE_GREEN, PH_GREEN, 2, 4);
        seg(CODE_OFF, PH_BLINK_OFF, 1, 1);
        seg(CODE_GREEN, PH_BLINK_ON, 1, 1);
        seg(CODE_OFF, PH_BLINK_OFF, 1, 1);
        seg(CODE_GREEN, PH_BLINK_ON, 1, 1);
    endtask

    // From GREEN cnt=1 through to the next GREEN entry, which carries the done pulse.
    task automatic rest_of_cycle();
        green_and_blink();
        seg(CODE_YELLOW, PH_YELLOW, 1, 2);
        seg(CODE_RED, PH_RED, 1, 3);
        step(CODE_GREEN, 1'b1, PH_GREEN, 1, 1'b1, 1'b0, 1'b1);
    endtask

    // Scoreboard monitor: every edge with a pending expectation is compared.
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("phase", int'(phase_o), int'(e[10:8]));
                chk("cnt", int'(phase_cnt_o), int'(e[7:5]));
                chk("locked", int'(locked_o), int'(e[4]));
                chk("err", int'(err_o), int'(e[3]));
                chk("err_code", int'(err_code_o), int'(e[2:1]));
                chk("done", int'(cycle_done_o), int'(e[0]));
            end
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        e_code   = 2'd0;
        rstn     = 1'b0;
        en_i     = 1'b1;
        color_i  = CODE_OFF;
        @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Nominal: green without preceding red must not lock, then four legal cycles.
        unl(CODE_OFF);
        unl(CODE_GREEN);
        unl(CODE_RED);
        lock_green();
        for (int n = 0; n < 4; n++) rest_of_cycle();

        // Long green: fifth consecutive green sample.
        seg(CODE_GREEN, PH_GREEN, 2, 4);
        err_step(CODE_GREEN, 2'd2);

        // Short yellow, then resync and one full legal cycle before a done pulse.
        unl(CODE_RED);
        lock_green();
        green_and_blink();
        seg(CODE_YELLOW, PH_YELLOW, 1, 1);
        err_step(CODE_RED, 2'd1);
        unl(CODE_RED);
        unl(CODE_RED);
        lock_green();
        rest_of_cycle();

        // Illegal code in RED; illegal code while unlocked is silent.
        green_and_blink();
        seg(CODE_YELLOW, PH_YELLOW, 1, 2);
        seg(CODE_RED, PH_RED, 1, 1);
        err_step(3'b110, 2'd0);
        unl(3'b110);
        unl(3'b110);
        unl(CODE_RED);
        lock_green();

        // Bad order: red straight after the last blink.
        green_and_blink();
        err_step(CODE_RED, 2'd3);

        // Enable dropped mid-green, lock only after a fresh red->green.
        unl(CODE_RED);
        lock_green();
        seg(CODE_GREEN, PH_GREEN, 2, 2);
        step(CODE_GREEN, 1'b0, PH_IDLE, 0, 1'b0, 1'b0, 1'b0);
        step(CODE_GREEN, 1'b0, PH_IDLE, 0, 1'b0, 1'b0, 1'b0);
        unl(CODE_GREEN);
        unl(CODE_GREEN);
        unl(CODE_RED);
        lock_green();

        // Asynchronous reset while in BLINK_OFF.
        seg(CODE_GREEN, PH_GREEN, 2, 4);
        seg(CODE_OFF, PH_BLINK_OFF, 1, 1);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(posedge clk);
        @(negedge clk);
        rstn   = 1'b1;
        e_code = 2'd0;
        unl(CODE_GREEN);
        unl(CODE_GREEN);
        unl(CODE_RED);
        lock_green();
        rest_of_cycle();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        chk("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the `color_out` bus of the traffic-light controller.
- Decodes the lamp code into a phase and measures every phase length in clock cycles.
- Flags illegal codes, wrong phase order and wrong durations, and reports each completed light cycle.
- Instantiated next to the controller in the top level and in the bench scoreboard.

Parameters:
- GREEN_ON, 40, steady-green cycles.
- YELLOW_ON, 5, yellow cycles.
- RED_ON, 15, red cycles.
- BLINKING, 3, green blink periods; each period is 1 cycle off then 1 cycle green.
- CNT_W, $clog2(max(GREEN_ON,YELLOW_ON,RED_ON,2))+1, width of the phase counter.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- en_i  input  1  controller enable, same net as the controller's
- color_i  input  3  observed lamp code: [2]=red, [1]=yellow, [0]=green
- phase_o  output  3  decoded phase: IDLE=0, GREEN=1, BLINK_OFF=2, BLINK_ON=3, YELLOW=4, RED=5
- phase_cnt_o  output  CNT_W  cycles spent in the current segment, 1-based
- locked_o  output  1  monitor is synchronised to the sequence
- err_o  output  1  one-cycle error pulse
- err_code_o  output  2  0=ILLEGAL_CODE, 1=TOO_SHORT, 2=TOO_LONG, 3=BAD_ORDER; held until the next error
- cycle_done_o  output  1  one-cycle pulse per completed, fully legal GREEN..RED cycle

Behaviour:
- Reset: all outputs 0. `phase_o` = IDLE. FSM in UNLOCKED.
- Legal codes: 3'b001, 3'b010, 3'b100, 3'b000. Any other code is ILLEGAL_CODE.
- Required sequence:
  - GREEN: 001 for GREEN_ON cycles.
  - Blink: BLINKING × (000 for 1 cycle, then 001 for 1 cycle).
  - YELLOW: 010 for YELLOW_ON cycles.
  - RED: 100 for RED_ON cycles.
  - Then back to GREEN.
- All outputs are registered. Each response appears the cycle after the `color_i` sample that causes it.
- States: UNLOCKED, GREEN, BLINK_OFF, BLINK_ON, YELLOW, RED.
- `blink_idx` counts completed blink periods, 0..BLINKING-1.
- UNLOCKED:
  - `phase_o` = IDLE, `locked_o` = 0.
  - Waits for a sample of 001 whose previous sample was 100.
  - On that sample: enter GREEN, cnt=1, `locked_o`=1.
  - No errors are ever raised while UNLOCKED.
- Locked, sample equals the current segment's code:
  - If cnt == expected length: TOO_LONG.
  - Otherwise cnt++.
- Locked, sample differs from the current code:
  - ILLEGAL_CODE if the code is illegal.
  - Else TOO_SHORT if cnt != expected.
  - Else BAD_ORDER if the code is not the next expected one.
  - Else advance, cnt=1.
- Check priority: ILLEGAL_CODE > TOO_SHORT > BAD_ORDER.
- Blink transitions:
  - BLINK_OFF → BLINK_ON.
  - BLINK_ON → BLINK_OFF while `blink_idx` < BLINKING-1; `blink_idx` increments on each such BLINK_ON exit.
  - Last BLINK_ON → YELLOW.
  - BLINKING=0: GREEN → YELLOW directly.
  - GREEN and BLINK_ON share code 001. The GREEN→blink boundary is detected only by a change to 000 after exactly GREEN_ON cycles.
- Any error:
  - `err_o` pulses, `err_code_o` is updated, the FSM returns to UNLOCKED, `locked_o`=0.
  - Resynchronisation uses the normal UNLOCKED rule.
- `cycle_done_o` pulses on the RED→GREEN transition, only if the cycle that just ended started at a locked GREEN entry with no error since.
  - The first GREEN after lock does not pulse.
- `en_i` = 0:
  - FSM forced to UNLOCKED on the next edge, `phase_o`=IDLE, cnt=0; no errors, no pulses.
  - Re-enable requires a fresh resync.
- `phase_cnt_o` saturates at 2^CNT_W-1 and never wraps. TOO_LONG fires before saturation is possible.
- Reset asserted mid-operation: immediate return to reset values. No pulse is generated by the reset edge itself.

Decomposition:
- Package `traffic_light_pkg`:
  - lamp-code localparams: CODE_RED, CODE_YELLOW, CODE_GREEN, CODE_OFF.
  - typedef enum `phase_e` (3 bits).
  - typedef enum `err_code_e` (2 bits).
  - Shared with the controller.
- Sub-module `tl_seg_counter`:
  - Segment counter with clear / increment / saturate.
  - Compare-to-expected output.
- Main module:
  - FSM, blink counter, expected-length mux, error and done logic.

Test Plan:
- Parameters for all scenarios: GREEN_ON=4, YELLOW_ON=2, RED_ON=3, BLINKING=2 (legal cycle = 13 clocks).
- Nominal: driven by the real controller, `en_i`=1 for 60 cycles → `locked_o`=1 one cycle after the first RED→GREEN sample; `cycle_done_o` pulses every 13 cycles from the second GREEN entry; `err_o` never high.
- Long green: drive 5 samples of 001 after lock → `err_o` pulse with `err_code_o`=2 on the cycle after the 5th sample; `locked_o`=0.
- Short yellow: 1 sample of 010, then 100 → `err_code_o`=1; no `cycle_done_o` afterwards until resync plus one full legal cycle.
- Illegal code: inject 3'b110 during RED → `err_code_o`=0. Inject 3'b110 while UNLOCKED → no `err_o`.
- Order: after a full green and blink, drive 100 instead of 010 → `err_code_o`=3. Mid-GREEN `en_i`=0 for 2 cycles → `phase_o`=IDLE, no error; lock returns after the next RED→GREEN.
- Reset: `rstn` low in BLINK_OFF → all outputs 0 immediately. After `rstn` release, `locked_o` stays 0 until a RED→GREEN is seen.
